// File: rtl/pe_link_pkg.sv
// rtl/pe_link_pkg.sv - shared link bit positions, receive FSM states and width check
package pe_link_pkg;

  localparam int LINK_AXIS_WIDTH = 128;
  localparam int LINK_VALID_BIT  = LINK_AXIS_WIDTH + 1;
  localparam int LINK_CREDIT_BIT = LINK_AXIS_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } link_state_e;

  function automatic bit link_width_ok(input int axis_width, input int west_width);
    return west_width == axis_width + 2;
  endfunction

endpackage

// File: rtl/pe_link_fifo.sv
// rtl/pe_link_fifo.sv - show-ahead FIFO with occupancy count, shared by all mesh receive endpoints
module pe_link_fifo #(
  parameter int WIDTH     = 128,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic                 empty,
  output logic                 full,
  output logic [ADDR_BITS:0]   count
);

  localparam int CW    = ADDR_BITS + 1;
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // A pop on the same edge frees the slot, so a push into a full FIFO is accepted then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head word is read combinationally; forced to zero when empty so nothing stale leaks out.
  assign dout = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pe_link_rx_west.sv
// rtl/pe_link_rx_west.sv - west receive endpoint of the inter-PE mesh link
// Buffers incoming link words and returns one credit per freed slot after an initial DEPTH grant.
module pe_link_rx_west
  import pe_link_pkg::*;
#(
  parameter int AXIS_WIDTH     = LINK_AXIS_WIDTH,
  parameter int WEST_WIDTH     = LINK_AXIS_WIDTH + 2,
  parameter int FIFO_ADDR_BITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ap_start,
  input  logic [WEST_WIDTH-1:0]     in_from_west,
  output logic [WEST_WIDTH-1:0]     out_to_west,
  output logic [AXIS_WIDTH-1:0]     dout,
  output logic                      val_out,
  input  logic                      ready_downward,
  output logic [FIFO_ADDR_BITS:0]   fifo_count,
  output logic                      proto_err
);

  localparam int CW        = FIFO_ADDR_BITS + 1;
  localparam int VALID_BIT = AXIS_WIDTH + 1;
  localparam int CRED_BIT  = AXIS_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(1 << FIFO_ADDR_BITS);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  if (!link_width_ok(AXIS_WIDTH, WEST_WIDTH)) begin : g_width_err
    $error("pe_link_rx_west: WEST_WIDTH must equal AXIS_WIDTH+2");
  end

  link_state_e   state_q, state_d;
  logic [CW-1:0] grant_q, grant_d;
  logic [CW-1:0] pend_q, pend_d;
  logic          credit_q, credit_d;
  logic          err_q, err_d;

  logic          link_valid, fifo_empty, fifo_full, pop, push;
  logic          unused_link_credit;

  assign link_valid         = in_from_west[VALID_BIT];
  assign unused_link_credit = in_from_west[CRED_BIT];

  assign val_out = !fifo_empty;
  assign pop     = val_out && ready_downward;
  assign push    = link_valid && (state_q != IDLE) && (!fifo_full || pop);

  pe_link_fifo #(
    .WIDTH    (AXIS_WIDTH),
    .ADDR_BITS(FIFO_ADDR_BITS)
  ) u_fifo (
    .clk  (clk),
    .rst_n(reset),
    .push (push),
    .pop  (pop),
    .din  (in_from_west[AXIS_WIDTH-1:0]),
    .dout (dout),
    .empty(fifo_empty),
    .full (fifo_full),
    .count(fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    pend_d   = pend_q;
    credit_d = 1'b0;
    err_d    = err_q | (link_valid && ((state_q == IDLE) || (fifo_full && !pop)));
    case (state_q)
      IDLE: begin
        if (ap_start) begin
          state_d  = INIT;
          grant_d  = DEPTH_C;
          credit_d = 1'b1;
        end
      end
      INIT: begin
        // grant_q counts pulses still on the wire including the current one.
        credit_d = (grant_q > ONE_C);
        grant_d  = grant_q - ONE_C;
        if (grant_q <= ONE_C) state_d = RUN;
        if (pop && (pend_q != DEPTH_C)) pend_d = pend_q + ONE_C;
      end
      RUN: begin
        credit_d = pop || (pend_q != '0);
        if (!pop && (pend_q != '0)) pend_d = pend_q - ONE_C;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      pend_q   <= '0;
      credit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      pend_q   <= pend_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    out_to_west           = '0;
    out_to_west[CRED_BIT] = credit_q;
  end

  assign proto_err = err_q;

endmodule

// File: doc/pe_link_rx_west.md
Name: pe_link_rx_west

Overview:
- Receive endpoint of the inter-PE mesh link, for the west side of a PE.
- A neighbour's east-going link bundle (data, valid, credit) arrives on in_from_west. Words are buffered in a local FIFO and presented on the PE's AXIS-style output stream (dout/val_out/ready_downward).
- Flow control back to the sender is credit-based, on out_to_west: one credit pulse per freed FIFO slot, plus an initial credit grant after ap_start.

Parameters:
- AXIS_WIDTH, 128, payload width of link words and of dout.
- WEST_WIDTH, 130, link bundle width. Must equal AXIS_WIDTH+2.
- FIFO_ADDR_BITS, 4, log2 of FIFO depth. DEPTH = 2**FIFO_ADDR_BITS = 16.

Ports:
- clk  input  1  sole clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset. reset=0 clears all state immediately.
- ap_start  input  1  start request; sampled only in IDLE.
- in_from_west  input  WEST_WIDTH  link bundle: [AXIS_WIDTH+1]=valid, [AXIS_WIDTH]=credit (ignored by this block), [AXIS_WIDTH-1:0]=data.
- out_to_west  output  WEST_WIDTH  link bundle back to the sender. Only [AXIS_WIDTH] (credit) is driven; all other bits are 0.
- dout  output  AXIS_WIDTH  head-of-FIFO data.
- val_out  output  1  dout valid.
- ready_downward  input  1  consumer ready.
- fifo_count  output  FIFO_ADDR_BITS+1  current occupancy, 0..DEPTH.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset values: out_to_west=0, dout=0, val_out=0, fifo_count=0, proto_err=0, state=IDLE. Reset mid-operation discards FIFO contents and any remaining credit-grant count.
- State machine:
  - IDLE: ap_start=1 -> INIT, with credit counter loaded to DEPTH.
  - INIT: drive one credit pulse (out_to_west[AXIS_WIDTH]=1) per cycle for DEPTH consecutive cycles, then -> RUN.
  - RUN: terminal until reset. ap_start is ignored in INIT and RUN.
- Push:
  - Condition: in_from_west valid=1, state in {INIT, RUN}, FIFO not full.
  - The data word is written at that clock edge.
- Push when not allowed:
  - Valid=1 in IDLE, or valid=1 with FIFO full (and no pop that cycle): word dropped, proto_err set.
  - proto_err clears only on reset.
- Pop:
  - Condition: val_out && ready_downward.
  - The FIFO is show-ahead: dout holds the head word whenever val_out=1. dout is don't-care when val_out=0 (after reset it is 0).
- Latency:
  - A word pushed at edge t into an empty FIFO gives val_out=1 with that word on dout in the cycle after edge t. This is one cycle of latency.
  - No bypass path from in_from_west to dout.
- Credit return in RUN:
  - Each pop at edge t produces out_to_west[AXIS_WIDTH]=1 for exactly the cycle following t. The credit path is registered.
  - Pops during INIT (possible once the sender has credits) are counted separately.
  - Their credits are emitted after the INIT grant finishes, one per cycle, merged with live pops.
  - The pending-credit counter saturates at DEPTH; this is never exceeded with a compliant sender.
  - Total credits emitted in each cycle are at most 1.
- Simultaneous push and pop:
  - Both are legal in the same cycle, including when the FIFO is full (the pop frees the slot, the push succeeds, no error) and when it is empty (push only; val_out was 0 so no pop).
  - fifo_count is unchanged on simultaneous push+pop.
- Wrap-around: read/write pointers are FIFO_ADDR_BITS wide and wrap modulo DEPTH. Full/empty are derived from the occupancy counter.
- Sender contract: the sender holds zero credits out of reset and sends only when holding credits. Under that contract proto_err never asserts.

Decomposition:
- Shared package pe_link_pkg holds:
  - link bit-position constants: LINK_VALID_BIT=AXIS_WIDTH+1, LINK_CREDIT_BIT=AXIS_WIDTH;
  - the state enum (IDLE, INIT, RUN);
  - a width-check function asserting WEST_WIDTH==AXIS_WIDTH+2.
- One sub-module, pe_link_fifo: synchronous show-ahead FIFO with parameters WIDTH and ADDR_BITS, and ports push, pop, din, dout, empty, full, count. It is reusable by the north/south receive endpoints.
- The top level holds the FSM, credit counters, error flag and link packing.

Test Plan:
1. Reset: assert reset=0 with traffic active -> all outputs 0 in the same cycle. After release, state is IDLE and out_to_west=0.
2. ap_start pulse -> exactly 16 consecutive credit pulses on out_to_west[128], starting the cycle after ap_start is sampled. No further pulses when idle.
3. In RUN, push data=0xA5A5 with ready_downward=1:
   - val_out=1 with dout=0xA5A5 one cycle after the push edge;
   - popped the same cycle;
   - one credit pulse in the following cycle;
   - fifo_count returns to 0.
4. ready_downward=0, push 16 words 0..15 -> fifo_count=16, proto_err=0. Then:
   - a 17th push with no pop -> word dropped, proto_err=1 sticky;
   - release ready -> words 0..15 drain in order with 16 credit pulses.
5. FIFO full, then a simultaneous push and pop on one edge -> no error, fifo_count stays 16. The new word emerges last.
6. Valid word in IDLE -> proto_err=1, val_out stays 0. Then reset mid-INIT (after 5 credits) -> credits stop immediately, and the next ap_start re-grants the full 16.
